// File: rtl/alu_pkg.sv
// alu_pkg: shared width default and operation encodings for the alu block.
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_NOR = 3'b100,
        OP_SRL = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: shared adder/subtractor with signed overflow.
// Ports: a, b operands; sub selects a-b; sum result (carry-out dropped); ovf signed overflow.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
        // Same-sign effective operands producing an opposite-sign sum.
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

// File: rtl/alu.sv
// alu: execute-stage ALU with a one-cycle registered result.
// Ports: clk, rst_n (async active-low); A, B operands; ALU_operation op select;
// res registered result; zero registered res==0; overflow registered signed
// overflow for ADD/SUB, present only when ALU_OVERFLOW_EN is defined.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_operation,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] res,
    output logic             zero
);
    localparam int SW = $clog2(WIDTH);
    alu_op_e          op;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [WIDTH-1:0] res_d, res_q;
    logic             zero_d, zero_q;
    assign op = alu_op_e'(ALU_operation);
    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (A),
        .b   (B),
        .sub (op == OP_SUB || op == OP_SLT),
        .sum (sum),
        .ovf (ovf)
    );
    always_comb begin
        res_d = '0;
        case (op)
            OP_AND: res_d = A & B;
            OP_OR:  res_d = A | B;
            OP_ADD: res_d = sum;
            OP_XOR: res_d = A ^ B;
            OP_NOR: res_d = ~(A | B);
            OP_SRL: res_d = A >> B[SW-1:0];
            OP_SUB: res_d = sum;
            // Overflow flips the sign of the difference, so correct it.
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end
    assign res  = res_q;
    assign zero = zero_q;
`ifdef ALU_OVERFLOW_EN
    logic overflow_d, overflow_q;
    assign overflow_d = ovf && (op == OP_ADD || op == OP_SUB);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end
    assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif
    int checks = 0;
    int failures = 0;

    alu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (a),
        .B             (b),
        .ALU_operation (op),
`ifdef ALU_OVERFLOW_EN
        .overflow      (overflow),
`endif
        .res           (res),
        .zero          (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
        @(negedge clk);
        op = o; a = x; b = y;
        @(posedge clk);
        #1;
        check({tag, "_res"}, res, exp);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
    endtask

    initial begin
        rst_n = 1'b1; a = '0; b = '0; op = 3'b000;
        #1 rst_n = 1'b0;
        #1;
        check("rst_res", res, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h1);
`ifdef ALU_OVERFLOW_EN
        check("rst_ovf", {31'b0, overflow}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run("slt_a5", 3'b111, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h1);
        run("slt_zero", 3'b111, 32'd0, 32'd12345678, 32'h1);
        run("slt_big", 3'b111, 32'd87654321, 32'd12345678, 32'h0);
        run("slt_f1", 3'b111, 32'hF1111110, 32'h0EEEEEEF, 32'h1);
        run("and", 3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0);
        run("or", 3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF);
        run("xor", 3'b011, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF);
        run("nor", 3'b100, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0);
        run("nor_ones", 3'b100, 32'h0000F000, 32'h0000000F, 32'hFFFF0FF0);
        run("add", 3'b010, 32'hF1111110, 32'h0EEEEEEF, 32'hFFFFFFFF);
        run("sub", 3'b110, 32'd87654321, 32'd12345678, 32'd75308643);
        run("add_wrap", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
        run("sub_eq", 3'b110, 32'h12345678, 32'h12345678, 32'h0);
        run("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
`ifdef ALU_OVERFLOW_EN
        check("add_ovf_flag", {31'b0, overflow}, 32'h1);
`endif
        run("sub_ovf", 3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF);
`ifdef ALU_OVERFLOW_EN
        check("sub_ovf_flag", {31'b0, overflow}, 32'h1);
`endif
        run("slt_corner1", 3'b111, 32'h80000000, 32'h00000001, 32'h1);
`ifdef ALU_OVERFLOW_EN
        check("slt_ovf_flag", {31'b0, overflow}, 32'h0);
`endif
        run("slt_corner2", 3'b111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0);
        run("slt_eq", 3'b111, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0);
        run("srl4", 3'b101, 32'hF1111110, 32'd4, 32'h0F111111);
        run("srl0", 3'b101, 32'hF1111110, 32'h00000020, 32'hF1111110);
        run("srl31", 3'b101, 32'hF1111110, 32'd31, 32'h1);
        run("srl_pre_rst", 3'b001, 32'h00001234, 32'h00000000, 32'h00001234);

        #2 rst_n = 1'b0;
        #1;
        check("async_rst_res", res, 32'h0);
        check("async_rst_zero", {31'b0, zero}, 32'h1);
        @(posedge clk);
        #1;
        check("held_rst_res", res, 32'h0);
        @(negedge clk);
        op = 3'b010; a = 32'd100; b = 32'd23;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_res", res, 32'd123);
        check("post_rst_zero", {31'b0, zero}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
